// File: rtl/rv32i_prefetch_fetch_unit.sv
// RV32I prefetching fetch stage: in-order imem requests, prefetch FIFO,
// valid/ready decode handoff, redirect flush with stale-response dropping.
module rv32i_prefetch_fetch_unit #(
  parameter int                   WORD_SIZE  = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
  parameter int                   FIFO_DEPTH = 4,
  parameter logic [WORD_SIZE-1:0] NOOP       = 'h13
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_redirect,
  input  logic [WORD_SIZE-1:0] i_redirect_pc,
  output logic                 o_imem_req_valid,
  input  logic                 i_imem_req_ready,
  output logic [WORD_SIZE-1:0] o_imem_req_addr,
  input  logic                 i_imem_rsp_valid,
  input  logic [WORD_SIZE-1:0] i_imem_rsp_data,
  output logic                 o_fd_valid,
  input  logic                 i_fd_ready,
  output logic [WORD_SIZE-1:0] o_fd_instr,
  output logic [WORD_SIZE-1:0] o_fd_pc,
  output logic [WORD_SIZE-1:0] o_fetch_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(FIFO_DEPTH);
  localparam logic [WORD_SIZE-1:0] STEP = WORD_SIZE'(4);

  typedef struct packed {
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] instr;
  } fq_entry_t;

  fq_entry_t            fq_mem [FIFO_DEPTH];
  fq_entry_t            head;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        live;
  logic [CW-1:0]        drop;
  logic [WORD_SIZE-1:0] fetch_pc;
  logic [WORD_SIZE-1:0] rsp_pc;
  logic [WORD_SIZE-1:0] tgt_pc;
  logic [CW:0]          credit_used;
  logic [CW:0]          drop_sum;
  logic                 req_fire;
  logic                 rsp_drop;
  logic                 rsp_keep;
  logic                 push;
  logic                 pop;
  logic                 unused_lsb;

  assign unused_lsb = ^i_redirect_pc[1:0];
  assign tgt_pc = {i_redirect_pc[WORD_SIZE-1:2], 2'b00};

  // Every slot of credit is held by a live, dropped or buffered entry.
  assign credit_used = {1'b0, live} + {1'b0, drop} + {1'b0, count};

  assign o_imem_req_valid = i_rst && !i_redirect
                         && (credit_used < DEPTH);
  assign o_imem_req_addr  = fetch_pc;
  assign o_fetch_pc       = fetch_pc;

  assign req_fire = o_imem_req_valid && i_imem_req_ready;
  assign rsp_drop = i_imem_rsp_valid && (drop != '0);
  assign rsp_keep = i_imem_rsp_valid && (drop == '0)
                 && (live != '0);
  assign push     = rsp_keep && !i_redirect;
  assign pop      = o_fd_valid && i_fd_ready && !i_redirect;

  // Everything in flight at a redirect becomes stale.
  assign drop_sum = {1'b0, drop} + {1'b0, live}
                  + {{CW{1'b0}}, req_fire}
                  - {{CW{1'b0}}, rsp_drop | rsp_keep};

  assign head       = fq_mem[rd_ptr];
  assign o_fd_valid = (count != '0);
  assign o_fd_instr = o_fd_valid ? head.instr : NOOP;
  assign o_fd_pc    = o_fd_valid ? head.pc : '0;

  always_ff @(posedge i_clk) begin
    if (push) begin
      fq_mem[wr_ptr] <= '{pc: rsp_pc, instr: i_imem_rsp_data};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      live     <= '0;
      drop     <= '0;
    end else if (i_redirect) begin
      fetch_pc <= tgt_pc;
      rsp_pc   <= tgt_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      live     <= '0;
      drop     <= drop_sum[CW-1:0];
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + STEP;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rsp_pc <= rsp_pc + STEP;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      live <= live + CW'(req_fire) - CW'(rsp_keep);
      drop <= drop - CW'(rsp_drop);
    end
  end

endmodule
